// File: rtl/qam16_demod_pkg.sv
// Shared 16-QAM constants: constellation levels, decision threshold, guard band,
// Gray codes and the sample/decision payload layouts used by mapper and demapper.
package qam16_demod_pkg;

   localparam int unsigned QAM16_COMP_W = 16;
   localparam int unsigned QAM16_DAT_W  = 2 * QAM16_COMP_W;
   localparam int unsigned QAM16_DEC_W  = 6;
   localparam int unsigned QAM16_CNT_W  = 16;

   // Constellation levels, Q1.15
   localparam logic signed [QAM16_COMP_W-1:0] QAM16_LVL_N3 = 16'sh8692;
   localparam logic signed [QAM16_COMP_W-1:0] QAM16_LVL_N1 = 16'shD786;
   localparam logic signed [QAM16_COMP_W-1:0] QAM16_LVL_P1 = 16'sh287A;
   localparam logic signed [QAM16_COMP_W-1:0] QAM16_LVL_P3 = 16'sh796E;

   // Inner/outer threshold (midpoint of the 1 and 3 levels) and low-confidence half-width
   localparam logic signed [QAM16_COMP_W-1:0] QAM16_THR_DEF   = 16'sh50F4;
   localparam logic signed [QAM16_COMP_W-1:0] QAM16_GUARD_DEF = 16'sh0800;

   // Per-axis Gray codes, written as {b1, b0}
   localparam logic [1:0] QAM16_GRAY_N3 = 2'b00;
   localparam logic [1:0] QAM16_GRAY_N1 = 2'b10;
   localparam logic [1:0] QAM16_GRAY_P1 = 2'b11;
   localparam logic [1:0] QAM16_GRAY_P3 = 2'b01;

   // Complex sample as carried on the stream bus
   typedef struct packed {
      logic signed [QAM16_COMP_W-1:0] im;
      logic signed [QAM16_COMP_W-1:0] re;
   } qam16_sample_t;

   // Symbol decision as carried on the stream bus
   typedef struct packed {
      logic [1:0] pad;
      logic [1:0] im;
      logic [1:0] re;
   } qam16_dec_t;

endpackage

// File: rtl/qam16_demod_slice_axis.sv
// Combinational per-component hard slicer: signed sample -> 2-bit Gray code.
// With QAM16_DEMOD_LOWCONF_EN it also flags samples close to a decision boundary.
module qam16_slice_axis
   import qam16_demod_pkg::*;
#(
   parameter logic signed [QAM16_COMP_W-1:0] THR = QAM16_THR_DEF
`ifdef QAM16_DEMOD_LOWCONF_EN
   ,
   parameter logic signed [QAM16_COMP_W-1:0] GUARD = QAM16_GUARD_DEF
`endif
) (
   input  logic signed [QAM16_COMP_W-1:0] x_i,
   output logic [1:0]                     gray_c_o
`ifdef QAM16_DEMOD_LOWCONF_EN
   ,
   output logic                           lowconf_c_o
`endif
);

   // Extra headroom so threshold +/- guard sums never wrap
   localparam int unsigned EXT_W = QAM16_COMP_W + 2;
   localparam logic signed [EXT_W-1:0] THR_X = EXT_W'(THR);

   logic signed [EXT_W-1:0] x_ext;
   logic                    b0_c;
   logic                    b1_c;

   assign x_ext = EXT_W'(x_i);

   // Sign bit and inner-region test; ties at +/-THR fall to the outer level
   always_comb begin
      b0_c     = ~x_i[QAM16_COMP_W-1];
      b1_c     = (x_ext > -THR_X) && (x_ext < THR_X);
      gray_c_o = {b1_c, b0_c};
   end

`ifdef QAM16_DEMOD_LOWCONF_EN
   localparam logic signed [EXT_W-1:0] GRD_X = EXT_W'(GUARD);

   // Within GUARD of zero or of either threshold
   always_comb begin
      lowconf_c_o = ((x_ext > -GRD_X)         && (x_ext < GRD_X))         ||
                    ((x_ext > THR_X - GRD_X)  && (x_ext < THR_X + GRD_X))  ||
                    ((x_ext > -THR_X - GRD_X) && (x_ext < -THR_X + GRD_X));
   end
`endif

endmodule

// File: rtl/qam16_demod.sv
// Hard-decision 16-QAM demapper: two-stage registered pipeline on a
// Wishbone-style stream with combinational back-pressure.
// Optional feature macro: QAM16_DEMOD_LOWCONF_EN adds a saturating
// low-confidence sample counter on LOWCONF_CNT_O.
module qam16_demod
   import qam16_demod_pkg::*;
#(
   parameter logic signed [QAM16_COMP_W-1:0] THR = QAM16_THR_DEF
`ifdef QAM16_DEMOD_LOWCONF_EN
   ,
   parameter logic signed [QAM16_COMP_W-1:0] GUARD = QAM16_GUARD_DEF
`endif
) (
   input  logic                   CLK_I,
   input  logic                   RST_I,
   input  logic [QAM16_DAT_W-1:0] DAT_I,
   input  logic                   CYC_I,
   input  logic                   STB_I,
   input  logic                   WE_I,
   output logic                   ACK_O,
   output logic [QAM16_DEC_W-1:0] DAT_O,
   output logic                   CYC_O,
   output logic                   STB_O,
   output logic                   WE_O,
   input  logic                   ACK_I
`ifdef QAM16_DEMOD_LOWCONF_EN
   ,
   output logic [QAM16_CNT_W-1:0] LOWCONF_CNT_O
`endif
);

   qam16_sample_t s1_dat_q, s1_dat_d;
   logic          s1_val_q, s1_val_d;
   qam16_dec_t    dat_q, dat_d;
   logic          stb_q, stb_d;
   logic          cyc1_q, cyc_q;

   logic          ena_c;
   logic          out_halt_c;
   logic          ack_c;
   logic [1:0]    re_gray_c;
   logic [1:0]    im_gray_c;

`ifdef QAM16_DEMOD_LOWCONF_EN
   logic                   re_lc_c;
   logic                   im_lc_c;
   logic [QAM16_CNT_W-1:0] cnt_q, cnt_d;

   qam16_slice_axis #(.THR(THR), .GUARD(GUARD)) u_slice_re (
      .x_i         (s1_dat_q.re),
      .gray_c_o    (re_gray_c),
      .lowconf_c_o (re_lc_c)
   );

   qam16_slice_axis #(.THR(THR), .GUARD(GUARD)) u_slice_im (
      .x_i         (s1_dat_q.im),
      .gray_c_o    (im_gray_c),
      .lowconf_c_o (im_lc_c)
   );
`else
   qam16_slice_axis #(.THR(THR)) u_slice_re (
      .x_i      (s1_dat_q.re),
      .gray_c_o (re_gray_c)
   );

   qam16_slice_axis #(.THR(THR)) u_slice_im (
      .x_i      (s1_dat_q.im),
      .gray_c_o (im_gray_c)
   );
`endif

   // Handshake: accept upstream unless the output is stalled
   always_comb begin
      ena_c      = CYC_I & STB_I & WE_I;
      out_halt_c = stb_q & ~ACK_I;
      ack_c      = ena_c & ~out_halt_c;
   end

   // Next-state for both pipeline stages; everything holds during a stall
   always_comb begin
      s1_dat_d = s1_dat_q;
      s1_val_d = s1_val_q;
      dat_d    = dat_q;
      stb_d    = stb_q;

      if (ack_c) begin
         s1_dat_d = qam16_sample_t'(DAT_I);
         s1_val_d = 1'b1;
      end else if (!out_halt_c) begin
         s1_val_d = 1'b0;
      end

      if (!out_halt_c) begin
         stb_d = s1_val_q;
         if (s1_val_q) begin
            dat_d.pad = 2'b00;
            dat_d.im  = im_gray_c;
            dat_d.re  = re_gray_c;
         end
      end
   end

   // Pipeline registers and the two-deep CYC delay line
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         s1_dat_q <= '0;
         s1_val_q <= 1'b0;
         dat_q    <= '0;
         stb_q    <= 1'b0;
         cyc1_q   <= 1'b0;
         cyc_q    <= 1'b0;
      end else begin
         s1_dat_q <= s1_dat_d;
         s1_val_q <= s1_val_d;
         dat_q    <= dat_d;
         stb_q    <= stb_d;
         cyc1_q   <= CYC_I;
         cyc_q    <= cyc1_q;
      end
   end

`ifdef QAM16_DEMOD_LOWCONF_EN
   // Count low-confidence samples as they enter stage 2, saturating at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (!out_halt_c && s1_val_q && (re_lc_c || im_lc_c) && (cnt_q != {QAM16_CNT_W{1'b1}})) begin
         cnt_d = cnt_q + QAM16_CNT_W'(1);
      end
   end

   // Low-confidence counter register; cleared only by reset
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign LOWCONF_CNT_O = cnt_q;
`endif

   assign ACK_O = ack_c;
   assign DAT_O = dat_q;
   assign STB_O = stb_q;
   assign WE_O  = stb_q;
   assign CYC_O = cyc_q;

endmodule

// File: tb/tb_qam16_demod.sv
// Self-checking bench for qam16_demod: directed cases plus random streaming
// against a transaction-level reference (decision by level ranges, FIFO of
// accepted samples tagged with their acceptance edge).
module tb_qam16_demod;

   localparam int THR_I   = 20724;
   localparam int GUARD_I = 2048;

   logic        clk;
   logic        RST_I;
   logic [31:0] DAT_I;
   logic        CYC_I, STB_I, WE_I, ACK_I;
   logic        ACK_O, CYC_O, STB_O, WE_O;
   logic [5:0]  DAT_O;
`ifdef QAM16_DEMOD_LOWCONF_EN
   logic [15:0] LOWCONF_CNT_O;
`endif

   qam16_demod dut (
      .CLK_I (clk),
      .RST_I (RST_I),
      .DAT_I (DAT_I),
      .CYC_I (CYC_I),
      .STB_I (STB_I),
      .WE_I  (WE_I),
      .ACK_O (ACK_O),
      .DAT_O (DAT_O),
      .CYC_O (CYC_O),
      .STB_O (STB_O),
      .WE_O  (WE_O),
      .ACK_I (ACK_I)
`ifdef QAM16_DEMOD_LOWCONF_EN
      ,
      .LOWCONF_CNT_O (LOWCONF_CNT_O)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] dec;
      int         ed;
   } ent_t;

   ent_t q[$];
   int   edge_n;
   int   n_assert;
   int   n_fail;
   int   lc_exp;

   // Level for a 2-bit Gray code
   function automatic logic [15:0] lvl_of(input logic [1:0] g);
      case (g)
         2'b00:   return 16'h8692;
         2'b10:   return 16'hD786;
         2'b11:   return 16'h287A;
         default: return 16'h796E;
      endcase
   endfunction

   // Nearest-level decision by ranges, returned as its Gray code
   function automatic logic [1:0] ref_axis(input logic [15:0] x);
      int v;
      v = int'($signed(x));
      if (v >= THR_I)       return 2'b01;
      else if (v >= 0)      return 2'b11;
      else if (v > -THR_I)  return 2'b10;
      else                  return 2'b00;
   endfunction

   function automatic logic [5:0] ref_dec(input logic [31:0] d);
      return {2'b00, ref_axis(d[31:16]), ref_axis(d[15:0])};
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic bit near(input logic [15:0] x);
      int v;
      v = int'($signed(x));
      return (iabs(v) < GUARD_I) || (iabs(v - THR_I) < GUARD_I) || (iabs(v + THR_I) < GUARD_I);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, check pre-edge outputs against the model, advance one edge
   task automatic drive_cycle(input logic [31:0] dat, input logic stb, input logic ackin,
                              input int forced, output logic acc);
      logic exp_stb;
      CYC_I = 1'b1;
      WE_I  = 1'b1;
      STB_I = stb;
      DAT_I = dat;
      ACK_I = ackin;
      @(negedge clk);
      exp_stb = (q.size() > 0) && (q[0].ed < edge_n);
      acc     = stb && !(exp_stb && !ackin);
      chk("stb_o", 32'(STB_O), 32'(exp_stb));
      chk("we_o", 32'(WE_O), 32'(exp_stb));
      chk("ack_o", 32'(ACK_O), 32'(acc));
      if (exp_stb) begin
         chk("dat_o", 32'(DAT_O), 32'(q[0].dec));
         if (ackin) void'(q.pop_front());
      end
      if (acc) begin
         q.push_back('{dec: (forced >= 0) ? 6'(forced) : ref_dec(dat), ed: edge_n + 1});
         if ((near(dat[15:0]) || near(dat[31:16])) && lc_exp < 65535) lc_exp++;
      end
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   task automatic drain();
      logic a;
      for (int i = 0; i < 20 && q.size() > 0; i++) drive_cycle(32'h0, 1'b0, 1'b1, -1, a);
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic        a;
      logic [31:0] d;
      logic [31:0] bnd_dat[5];
      logic [1:0]  bnd_exp[5];
      logic [31:0] burst[5];
      int          idx;
      int          cyc;

      n_assert = 0;
      n_fail   = 0;
      edge_n   = 0;
      lc_exp   = 0;
      RST_I = 1'b0;
      DAT_I = '0;
      CYC_I = 1'b0;
      STB_I = 1'b0;
      WE_I  = 1'b0;
      ACK_I = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dat", 32'(DAT_O), 32'd0);
      chk("rst_stb", 32'(STB_O), 32'd0);
      chk("rst_cyc", 32'(CYC_O), 32'd0);
      chk("rst_ack", 32'(ACK_O), 32'd0);
`ifdef QAM16_DEMOD_LOWCONF_EN
      chk("rst_cnt", 32'(LOWCONF_CNT_O), 32'd0);
`endif
      @(negedge clk);
      RST_I = 1'b1;
      @(posedge clk);
      edge_n++;
      #1;

      // Directed example points
      drive_cycle({16'h287A, 16'hD786}, 1'b1, 1'b1, -1, a);
      drive_cycle(32'h0, 1'b0, 1'b1, -1, a);
      chk("ex1_stb", 32'(STB_O), 32'd1);
      chk("ex1_dat", 32'(DAT_O), 32'h0E);
      drive_cycle({16'h8692, 16'h796E}, 1'b1, 1'b1, -1, a);
      drive_cycle(32'h0, 1'b0, 1'b1, -1, a);
      chk("ex2_dat", 32'(DAT_O), 32'h01);
      chk("cyc_on", 32'(CYC_O), 32'd1);
      drain();

      // All 16 mapper levels back to back: decision equals the mapper input
      for (int s = 0; s < 16; s++) begin
         d = {lvl_of(2'(s >> 2)), lvl_of(2'(s))};
         drive_cycle(d, 1'b1, 1'b1, s, a);
      end
      drain();

      // Re boundaries with Im = 0 (Im decides +1)
      bnd_dat[0] = 32'h0000_0000; bnd_exp[0] = 2'b11;
      bnd_dat[1] = 32'h0000_50F4; bnd_exp[1] = 2'b01;
      bnd_dat[2] = 32'h0000_AF0C; bnd_exp[2] = 2'b00;
      bnd_dat[3] = 32'h0000_8000; bnd_exp[3] = 2'b00;
      bnd_dat[4] = 32'h0000_7FFF; bnd_exp[4] = 2'b01;
      for (int i = 0; i < 5; i++) drive_cycle(bnd_dat[i], 1'b1, 1'b1, int'({2'b00, 2'b11, bnd_exp[i]}), a);
      drain();

      // Five-sample burst with a three-cycle downstream stall
      burst[0] = {16'h796E, 16'h8692};
      burst[1] = {16'hD786, 16'h287A};
      burst[2] = {16'h287A, 16'h796E};
      burst[3] = {16'h8692, 16'hD786};
      burst[4] = {16'h0000, 16'hAF0C};
      idx = 0;
      cyc = 0;
      while (idx < 5 && cyc < 30) begin
         drive_cycle(burst[idx], 1'b1, !(cyc >= 2 && cyc < 5), -1, a);
         if (a) idx++;
         cyc++;
      end
      chk("burst_all_accepted", 32'(idx), 32'd5);
      drain();

      // Asynchronous reset while STB_O is high
      drive_cycle({16'h287A, 16'h287A}, 1'b1, 1'b1, -1, a);
      drive_cycle({16'h796E, 16'h796E}, 1'b1, 1'b1, -1, a);
      chk("pre_rst_stb", 32'(STB_O), 32'd1);
      RST_I = 1'b0;
      #1;
      chk("arst_stb", 32'(STB_O), 32'd0);
      chk("arst_dat", 32'(DAT_O), 32'd0);
      chk("arst_cyc", 32'(CYC_O), 32'd0);
      q.delete();
      lc_exp = 0;
      STB_I  = 1'b0;
      @(negedge clk);
      RST_I = 1'b1;
      @(posedge clk);
      edge_n++;
      #1;

`ifdef QAM16_DEMOD_LOWCONF_EN
      // Three near-zero Re samples and two clean outer samples
      for (int i = 0; i < 3; i++) drive_cycle({16'h796E, 16'h0100}, 1'b1, 1'b1, -1, a);
      for (int i = 0; i < 2; i++) drive_cycle({16'h796E, 16'h796E}, 1'b1, 1'b1, -1, a);
      drain();
      chk("lowconf_cnt3", 32'(LOWCONF_CNT_O), 32'd3);
`else
      drive_cycle({16'h796E, 16'h0100}, 1'b1, 1'b1, -1, a);
      drain();
`endif

      // Random stream with random bubbles and back-pressure
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       d = {lvl_of(2'($urandom)), lvl_of(2'($urandom))};
            1:       d = {16'($urandom_range(0, 1) ? 16'h50F4 : 16'hAF0C) + 16'($urandom_range(0, 2)) - 16'd1,
                          16'($urandom_range(0, 1) ? 16'h8000 : 16'h0000) + 16'($urandom_range(0, 2))};
            default: d = $urandom;
         endcase
         drive_cycle(d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7), -1, a);
      end
      drain();
`ifdef QAM16_DEMOD_LOWCONF_EN
      chk("lowconf_model", 32'(LOWCONF_CNT_O), 32'(lc_exp));
`endif

      // CYC_O trails CYC_I by two edges
      CYC_I = 1'b0;
      STB_I = 1'b0;
      @(posedge clk);
      #1;
      chk("cyc_delay1", 32'(CYC_O), 32'd1);
      @(posedge clk);
      #1;
      chk("cyc_delay2", 32'(CYC_O), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/qam16_demod.md
# qam16_demod

Hard-decision 16-QAM demapper: accepts one complex baseband sample per Wishbone-style stream transfer and returns the 4-bit Gray-coded symbol decision. It is the receive-side counterpart of the 16-QAM mapper, sits after channel equalisation, and feeds the deinterleaver/decoder chain. The datapath is a two-stage registered pipeline with combinational back-pressure. An optional low-confidence counter supports link diagnostics.

## Interface
- THR, 16'sh50F4 (20724): inner/outer decision threshold, Q1.15; midpoint of the ±1 (0x287A) and ±3 (0x796E) levels
- GUARD, 16'sh0800: half-width of the low-confidence band around each threshold (used only with the counter feature)
- CLK_I  in  1  single clock, rising edge
- RST_I  in  1  reset, asynchronous, active-low
- DAT_I  in  32  sample {Im[31:16], Re[15:0]}, each signed Q1.15
- CYC_I, STB_I, WE_I  in  1 each  upstream cycle / strobe / write
- ACK_O  out  1  sample accepted
- DAT_O  out  6  decision; [5:4]=0, [3:2]=Im bits, [1:0]=Re bits
- CYC_O, STB_O  out  1 each  downstream cycle / strobe
- WE_O  out  1  equals STB_O
- ACK_I  in  1  downstream accept
- LOWCONF_CNT_O  out  16  saturating low-confidence count (present only with QAM16_DEMOD_LOWCONF_EN)

## Operation
- ena = CYC_I & STB_I & WE_I; out_halt = STB_O & ~ACK_I; ACK_O = ena & ~out_halt (combinational).
- Stage 1: on ACK_O, register DAT_I into s1_dat and set s1_val. When there is no ACK_O and there is no out_halt, clear s1_val. During out_halt, s1_dat and s1_val hold.
- Stage 2: when ~out_halt: if s1_val, then DAT_O <= slice(s1_dat) and STB_O <= 1; else STB_O <= 0. During out_halt, DAT_O and STB_O hold.
- Slicer, applied per component x (signed 16-bit):
  - b0 = (x >= 0)
  - b1 = (x > -THR) && (x < THR)
  - Gray mapping: 00 = -3, 10 = -1, 11 = +1, 01 = +3.
  - x = 0 decides +1. x = ±THR decides outer. 0x8000 decides -3.
  - Re gives DAT_O[1:0]; Im gives DAT_O[3:2].
- Signed compares only; no absolute value, so 0x8000 cannot overflow.
- CYC_O is CYC_I delayed by two registers, matching the pipeline depth. WE_O = STB_O.

## Timing
- Reset values: DAT_O=0, STB_O=0, CYC_O=0, s1_val=0, internal CYC delay=0, LOWCONF_CNT_O=0.
- Reset is asynchronous. Asserting it mid-stream drops any in-flight samples and deasserts STB_O immediately.
- Latency: a sample accepted at edge k is on DAT_O with STB_O=1 after edge k+1.
- Throughput is one sample per cycle while ACK_I=1.
- Stall: when STB_O=1 and ACK_I=0, ACK_O=0 in the same cycle and the pipeline freezes. The output is released on the first edge where ACK_I=1, with no loss and no duplication.
- Simultaneous events:
  - If ACK_I returns in the same cycle a new sample is offered, ACK_O=1. Stage 1 loads the new sample while stage 2 takes the old one.
  - Upstream bubbles (STB_I=0) produce STB_O=0 bubbles in the same position.

## Configuration
- QAM16_DEMOD_LOWCONF_EN defined:
  - A sample is low-confidence if, for Re or Im, |x| < GUARD or |x - THR| < GUARD or |x + THR| < GUARD.
  - Each low-confidence sample that advances into stage 2 increments LOWCONF_CNT_O by one. The counter saturates at 0xFFFF and clears only on reset.
- Undefined: the port, comparators and counter are absent. Decision behaviour is identical in both builds.

## Structure
- Shared package: constants QAM16_LVL_N3/N1/P1/P3 (0x8692, 0xD786, 0x287A, 0x796E), QAM16_THR_DEF, and the 2-bit Gray codes. Mapper and demapper both use them.
- One sub-module, qam16_slice_axis: a combinational per-component slicer (x → 2 bits, plus a low-confidence flag under the macro), instantiated twice.

## Test plan
- {Im=0x287A, Re=0xD786} with ACK_I=1 → DAT_O=0x0E one cycle after ACK_O. Also {0x8692, 0x796E} → 0x01.
- All 16 mapper levels streamed back-to-back → decisions equal the original 4-bit inputs; one output per cycle.
- Boundaries on Re: 0x0000→b=11; 0x50F4→01; 0xAF0C (-THR)→00; 0x8000→00; 0x7FFF→01.
- Hold ACK_I=0 for 3 cycles mid-burst of 5 samples → ACK_O low while stalled, DAT_O stable, all 5 decisions delivered in order.
- Assert RST_I low while STB_O=1 → STB_O, DAT_O, CYC_O go to 0 before the next edge. The stream resumes cleanly after release.
- With the macro: feed Re=0x0100 ×3 and Re=0x796E ×2 (Im=0x796E) → LOWCONF_CNT_O=3. Preload 0xFFFF via a long run → counter stays at 0xFFFF.
